uart_rx: RTL and testbench

Asynchronous serial receiver for 8N1 frames, LSB first, idle-high line. Oversamples the line on an externally generated 16x baud enable. It validates the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the byte on a valid/ack holding register. Sits between the chip's RX pad and the sensor's command/readout logic, sharing the baud generator with the transmit path.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame/oversampling defaults
// used by the receive path, transmit path and baud generator.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; both flops reset to 1
// so an idle-high line does not produce a false edge after reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled start validation, mid-bit data sampling,
// stop-bit check and a valid/ack holding register with frame/overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick16,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_error,
    output logic                 overrun_error
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    rx_state_e            state;
    rx_state_e            state_next;
    logic                 rx_s;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 armed;
    logic [DATA_BITS-1:0] shift_reg;

    logic start_c;
    logic start_end_c;
    logic bit_take_c;
    logic stop_ok_c;
    logic stop_bad_c;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; progress only on baud ticks
    always_comb begin
        state_next = state;
        if (baud_tick16) begin
            case (state)
                RX_IDLE: begin
                    if (armed && !rx_s) state_next = RX_START;
                end
                RX_START: begin
                    if (sample_cnt == HALF_LAST) state_next = rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (sample_cnt == BIT_LAST && bit_cnt == DATA_LAST) state_next = RX_STOP;
                end
                RX_STOP: begin
                    if (sample_cnt == BIT_LAST) state_next = RX_IDLE;
                end
            endcase
        end
    end

    // Per-tick decode of the sampling events
    always_comb begin
        start_c     = 1'b0;
        start_end_c = 1'b0;
        bit_take_c  = 1'b0;
        stop_ok_c   = 1'b0;
        stop_bad_c  = 1'b0;
        if (baud_tick16) begin
            start_c     = (state == RX_IDLE) && armed && !rx_s;
            start_end_c = (state == RX_START) && (sample_cnt == HALF_LAST);
            bit_take_c  = (state == RX_DATA) && (sample_cnt == BIT_LAST);
            stop_ok_c   = (state == RX_STOP) && (sample_cnt == BIT_LAST) && rx_s;
            stop_bad_c  = (state == RX_STOP) && (sample_cnt == BIT_LAST) && !rx_s;
        end
    end

    // Counters, arming and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            armed      <= 1'b0;
            shift_reg  <= '0;
        end else if (baud_tick16) begin
            case (state)
                RX_IDLE: begin
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    if (rx_s) armed <= 1'b1;
                end
                RX_START: begin
                    sample_cnt <= start_end_c ? '0 : sample_cnt + SW'(1);
                end
                RX_DATA: begin
                    if (bit_take_c) begin
                        sample_cnt <= '0;
                        bit_cnt    <= bit_cnt + BW'(1);
                        shift_reg  <= {rx_s, shift_reg[DATA_BITS-1:1]};
                    end else begin
                        sample_cnt <= sample_cnt + SW'(1);
                    end
                end
                RX_STOP: begin
                    if (sample_cnt == BIT_LAST) begin
                        sample_cnt <= '0;
                        // a low stop bit disarms until the line returns high
                        if (!rx_s) armed <= 1'b0;
                    end else begin
                        sample_cnt <= sample_cnt + SW'(1);
                    end
                end
            endcase
        end
    end

    // Holding register and status outputs; ack and pulses are per-clk
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_busy       <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            rx_busy       <= (state_next != RX_IDLE);
            frame_error   <= stop_bad_c;
            overrun_error <= stop_ok_c && rx_valid && !rx_ack;
            if (stop_ok_c) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random 8N1 frames compared against
// a frame-level reference model with cycle-exact completion prediction.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = TICK_DIV * int'(UART_OVERSAMPLE);
    // ticks from the first low tick to the stop-bit sample
    localparam int DONE_TICKS = int'(UART_OVERSAMPLE) / 2 + (int'(UART_DATA_BITS) + 1) * int'(UART_OVERSAMPLE);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick16 = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_error;
    logic       overrun_error;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int busy_cnt = 0;

    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    int         exp_fe = 0;
    int         exp_ov = 0;

    uart_rx dut (
        .clk           (clk),
        .reset         (reset),
        .baud_tick16   (baud_tick16),
        .rx            (rx),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // pulse/busy counters sampled just after each edge
    always @(posedge clk) begin
        #1;
        if (frame_error)   fe_seen  <= fe_seen + 1;
        if (overrun_error) ov_seen  <= ov_seen + 1;
        if (rx_busy)       busy_cnt <= busy_cnt + 1;
    end

    // one tick every TICK_DIV clocks, on posedges whose index is a multiple of TICK_DIV
    initial begin
        forever begin
            @(negedge clk);
            baud_tick16 = ((cyc + 1) % TICK_DIV == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_valid = 1'b0;
        chk("ack_valid", 32'(rx_valid), 32'(exp_valid));
        chk("ack_data", 32'(rx_data), 32'(exp_data));
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_fe_cnt"}, 32'(fe_seen), 32'(exp_fe));
        chk({tag, "_ov_cnt"}, 32'(ov_seen), 32'(exp_ov));
    endtask

    // Drive one frame; predicts the completion edge from sync latency + tick grid
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_done);
        logic [9:0] bits;
        int         p, t0, tc;
        logic       nv, n_fe, n_ov, seen;
        logic [7:0] nd;
        bits = {stop, d, 1'b0};
        p    = cyc + 1;
        t0   = ((p + 2 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
        tc   = t0 + DONE_TICKS * TICK_DIV;
        n_fe = !stop;
        n_ov = stop && exp_valid && !ack_done;
        nv   = stop ? 1'b1 : (exp_valid && !ack_done);
        nd   = stop ? d : exp_data;
        seen = 1'b0;
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            for (int k = 0; k < BIT_CLK; k++) begin
                rx_ack = ack_done && (cyc == tc - 1);
                @(negedge clk);
                if (cyc == tc - 1) begin
                    chk("pre_valid", 32'(rx_valid), 32'(exp_valid));
                    chk("pre_data", 32'(rx_data), 32'(exp_data));
                    chk("pre_busy", 32'(rx_busy), 32'd1);
                end else if (cyc == tc) begin
                    seen = 1'b1;
                    chk("done_valid", 32'(rx_valid), 32'(nv));
                    chk("done_data", 32'(rx_data), 32'(nd));
                    chk("done_frame_error", 32'(frame_error), 32'(n_fe));
                    chk("done_overrun", 32'(overrun_error), 32'(n_ov));
                    chk("done_busy", 32'(rx_busy), 32'd0);
                end
            end
        end
        rx_ack = 1'b0;
        if (!seen) chk("done_window", 32'd0, 32'd1);
        exp_valid = nv;
        exp_data  = nd;
        exp_fe   += int'(n_fe);
        exp_ov   += int'(n_ov);
        chk_counts("frame");
    endtask

    initial begin
        int b0;
        logic [7:0] rd;
        logic rs, ra;

        // reset state
        reset = 1'b1;
        rx    = 1'b1;
        hold(5);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_fe", 32'(frame_error), 32'd0);
        chk("rst_ov", 32'(overrun_error), 32'd0);
        reset = 1'b0;
        hold(BIT_CLK);

        // basic frame then ack, then ack while empty
        send_frame(8'h55, 1'b1, 1'b0);
        rx = 1'b1;
        hold(32);
        ack_pulse();
        ack_pulse();

        // start-bit glitch
        b0 = busy_cnt;
        rx = 1'b0;
        hold(2 * TICK_DIV);
        rx = 1'b1;
        hold(2 * BIT_CLK);
        chk("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
        chk("glitch_busy_now", 32'(rx_busy), 32'd0);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk_counts("glitch");

        // frame error followed by a long break
        send_frame(8'hA3, 1'b0, 1'b0);
        b0 = busy_cnt;
        hold(20 * BIT_CLK);
        chk("break_no_busy", 32'(busy_cnt), 32'(b0));
        chk_counts("break");
        rx = 1'b1;
        hold(2 * BIT_CLK);
        send_frame(8'h3C, 1'b1, 1'b0);
        rx = 1'b1;
        hold(BIT_CLK);

        // overrun
        ack_pulse();
        send_frame(8'h11, 1'b1, 1'b0);
        rx = 1'b1;
        hold(BIT_CLK);
        send_frame(8'h22, 1'b1, 1'b0);
        rx = 1'b1;
        hold(BIT_CLK);

        // ack on the completion edge
        send_frame(8'h7E, 1'b1, 1'b1);
        rx = 1'b1;
        hold(BIT_CLK);

        // reset in the middle of bit 4 of 0xFF
        rx = 1'b0;
        hold(BIT_CLK);
        rx = 1'b1;
        hold(4 * BIT_CLK + BIT_CLK / 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        chk("midrst_data", 32'(rx_data), 32'd0);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_busy", 32'(rx_busy), 32'd0);
        chk("midrst_fe", 32'(frame_error), 32'd0);
        chk("midrst_ov", 32'(overrun_error), 32'd0);
        hold(BIT_CLK / 2 - 1 + 3 * BIT_CLK + BIT_CLK);
        chk("midrst_after_valid", 32'(rx_valid), 32'd0);
        chk("midrst_after_data", 32'(rx_data), 32'd0);
        chk_counts("midrst");
        send_frame(8'h0F, 1'b1, 1'b0);
        rx = 1'b1;
        hold(BIT_CLK);

        // random frames, stop bits, acks and gaps
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom);
            rs = ($urandom % 4) != 0;
            ra = rs && (($urandom % 3) == 0);
            send_frame(rd, rs, ra);
            rx = 1'b1;
            hold(BIT_CLK + int'($urandom_range(0, 40)));
            if (($urandom % 2) == 1) ack_pulse();
        end
        chk_counts("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
